lowpass_seq: RTL

Sample sequencer placed in front of the 18-bit, 65-tap `lowpass` FIR filter. It buffers incoming samples in a small FIFO and issues one `endata` strobe per sample only while the filter is idle. It waits the filter's fixed processing time, then captures `dataout` into an output register with a valid/ready handshake. Sample loss at the source is flagged by a sticky overrun bit.

---
 rtl/lowpass_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/lowpass_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lowpass_pkg.sv
// Shared constants and types for the lowpass filter and its sample sequencer.
//   DW          : sample width of the filter datapath
//   RESULT_WAIT : edges from the endata sample edge to the result capture edge
//   NTAPS       : filter tap count; CADDR_W : coefficient ROM address width
package lowpass_pkg;

  localparam int unsigned DW          = 18;
  localparam int unsigned RESULT_WAIT = 132;
  localparam int unsigned NTAPS       = 65;
  localparam int unsigned CADDR_W     = 7;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the sequencer's input buffer.
//   clock, reset : clock and synchronous active-high reset
//   push_i/data_i: write request and data; ignored when full
//   pop_i        : read request; ignored when empty
//   head_c_o     : current head entry (combinational read of storage)
//   full_o/empty_o/count_o : registered occupancy status
module sync_fifo #(
  parameter int unsigned DW    = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [DW-1:0]                data_i,
  input  logic                         pop_i,
  output logic [DW-1:0]                head_c_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  // A simultaneous pop never makes room for a push in the same cycle
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  // Pointers and occupancy flags
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; occupancy flags guard every read
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign count_o  = count_q;

endmodule

// File: rtl/lowpass_seq.sv
// Sample sequencer in front of the lowpass FIR: buffers source samples,
// strobes the filter one sample at a time, waits out its processing time and
// presents each result through a valid/ready output register.
//   clock, reset                 : clock, synchronous active-high reset
//   in_data/in_valid/in_ready    : source sample interface
//   flt_datain/flt_endata        : sample and start strobe to the filter
//   flt_dataout                  : filter result
//   out_data/out_valid/out_ready : sink interface
//   busy                         : sequencer not idle
//   ovr_clr/overrun              : sticky dropped-sample flag and its clear
module lowpass_seq
  import lowpass_pkg::*;
#(
  parameter int unsigned DW          = lowpass_pkg::DW,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RESULT_WAIT = lowpass_pkg::RESULT_WAIT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] flt_datain,
  output logic          flt_endata,
  input  logic [DW-1:0] flt_dataout,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  input  logic          ovr_clr,
  output logic          overrun
);

  localparam int unsigned CNT_W = $clog2(RESULT_WAIT + 1);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    flt_datain_q, flt_datain_d;
  logic             flt_endata_q, flt_endata_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             fifo_pop;
  logic [DW-1:0]    fifo_head;
  logic             fifo_full, fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic             unused_fifo_count;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_i   (in_valid),
    .data_i   (in_data),
    .pop_i    (fifo_pop),
    .head_c_o (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // Occupancy is not needed by the sequencer
  assign unused_fifo_count = ^fifo_count;

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flt_datain_q <= '0;
      flt_endata_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flt_datain_q <= flt_datain_d;
      flt_endata_q <= flt_endata_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flt_datain_d = flt_datain_q;
    flt_endata_d = 1'b0;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    fifo_pop     = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Start only when the result slot is free or being consumed now
        if (!fifo_empty && (!out_valid_q || out_ready)) begin
          state_d      = LOAD;
          fifo_pop     = 1'b1;
          flt_datain_d = fifo_head;
          flt_endata_d = 1'b1;
        end
      end
      LOAD: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(RESULT_WAIT - 1);
      end
      WAIT: begin
        // The edge leaving WAIT is the capture edge; CAPTURE is the cycle after
        if (cnt_q == '0) begin
          state_d     = CAPTURE;
          out_data_d  = flt_dataout;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    // Sticky drop flag; a drop wins over a clear in the same cycle
    if (in_valid && fifo_full) overrun_d = 1'b1;
    else if (ovr_clr)          overrun_d = 1'b0;
    else                       overrun_d = overrun_q;
  end

  assign in_ready   = ~fifo_full;
  assign flt_datain = flt_datain_q;
  assign flt_endata = flt_endata_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
